// File: rtl/dst_serializer_pkg.sv
// Shared constants for the compressor result serializer: default sizing and FSM state codes.
package dst_serializer_pkg;

    localparam int DEFAULT_NUM_DST = 15;

    // Counter must be able to reach NUM_DST-1.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    localparam int DEFAULT_CNT_W = cnt_width(DEFAULT_NUM_DST);

    typedef logic [0:0] state_t;
    localparam state_t ST_IDLE  = 1'b0;
    localparam state_t ST_SHIFT = 1'b1;

endpackage

// File: rtl/dst_serializer_piso.sv
// Load/shift register with bit counter; flags the first and last bit of a frame.
module dst_piso
    import dst_serializer_pkg::*;
#(
    parameter int NUM_DST = DEFAULT_NUM_DST,
    parameter int CNT_W   = DEFAULT_CNT_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               shift,
    input  logic [NUM_DST-1:0] data,
    output logic               bit0,
    output logic               first,
    output logic               last
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_DST - 1);

    logic [NUM_DST-1:0] shreg;
    logic [CNT_W-1:0]   cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= '0;
        end else if (shift) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Data path carries no reset; the owning FSM gates everything it exposes.
    always_ff @(posedge clk) begin
        if (load) begin
            shreg <= data;
        end else if (shift) begin
            shreg <= shreg >> 1;
        end
    end

    assign bit0  = shreg[0];
    assign first = (cnt == '0);
    assign last  = (cnt == LAST_CNT);

endmodule

// File: rtl/dst_serializer.sv
// Captures compressor result bits on a strobe and emits them LSB-first on one framed serial pin.
module dst_serializer
    import dst_serializer_pkg::*;
#(
    parameter int NUM_DST = DEFAULT_NUM_DST,
    parameter int CNT_W   = DEFAULT_CNT_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_DST-1:0] dst,
    input  logic               capture,
    output logic               sout,
    output logic               sout_valid,
    output logic               sout_first,
    output logic               sout_last,
    output logic               busy,
    output logic               overflow
);

    state_t             state, state_n;
    logic [NUM_DST-1:0] pend, pend_n;
    logic               pend_full, pend_full_n;
    logic               ovf, ovf_n;
    logic               busy_r;

    logic               load, shift;
    logic [NUM_DST-1:0] load_data;
    logic               bit0, first, last;

    dst_piso #(
        .NUM_DST(NUM_DST),
        .CNT_W  (CNT_W)
    ) u_piso (
        .clk  (clk),
        .rst  (rst),
        .load (load),
        .shift(shift),
        .data (load_data),
        .bit0 (bit0),
        .first(first),
        .last (last)
    );

    always_comb begin
        state_n     = state;
        pend_n      = pend;
        pend_full_n = pend_full;
        ovf_n       = ovf;
        load        = 1'b0;
        shift       = 1'b0;
        load_data   = dst;
        case (state)
            ST_IDLE: begin
                if (capture) begin
                    load    = 1'b1;
                    state_n = ST_SHIFT;
                end
            end
            default: begin
                if (last) begin
                    // Frame boundary: a buffered frame goes first, a fresh capture refills the buffer.
                    if (pend_full) begin
                        load      = 1'b1;
                        load_data = pend;
                        if (capture) begin
                            pend_n = dst;
                        end else begin
                            pend_full_n = 1'b0;
                        end
                    end else if (capture) begin
                        load = 1'b1;
                    end else begin
                        state_n = ST_IDLE;
                    end
                end else begin
                    shift = 1'b1;
                    if (capture) begin
                        if (pend_full) begin
                            ovf_n = 1'b1;
                        end else begin
                            pend_n      = dst;
                            pend_full_n = 1'b1;
                        end
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            pend_full <= 1'b0;
            ovf       <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            state     <= state_n;
            pend_full <= pend_full_n;
            ovf       <= ovf_n;
            busy_r    <= (state_n == ST_SHIFT) | pend_full_n;
        end
    end

    always_ff @(posedge clk) begin
        pend <= pend_n;
    end

    assign sout_valid = (state == ST_SHIFT);
    assign sout       = sout_valid & bit0;
    assign sout_first = sout_valid & first;
    assign sout_last  = sout_valid & last;
    assign busy       = busy_r;
    assign overflow   = ovf;

endmodule
